// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared command, state and timeout constants for the I2C transfer controller
package i2c_pkg;

  localparam int TIMEOUT_CYC_DEF = 1024;

  // byte-engine command opcodes
  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_RSTART = 3'd1;
  localparam logic [2:0] OP_WR     = 3'd2;
  localparam logic [2:0] OP_RD     = 3'd3;
  localparam logic [2:0] OP_STOP   = 3'd4;

  // sequencer states
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START  = 4'd1;
  localparam logic [3:0] ST_DEV_W  = 4'd2;
  localparam logic [3:0] ST_REG    = 4'd3;
  localparam logic [3:0] ST_DATA_W = 4'd4;
  localparam logic [3:0] ST_RSTART = 4'd5;
  localparam logic [3:0] ST_DEV_R  = 4'd6;
  localparam logic [3:0] ST_DATA_R = 4'd7;
  localparam logic [3:0] ST_STOP   = 4'd8;
  localparam logic [3:0] ST_RESP   = 4'd9;

  // each command state is split into an issue phase and a wait-for-done phase
  localparam logic PH_ISSUE = 1'b0;
  localparam logic PH_WAIT  = 1'b1;

  // successor of a command state once the engine reports completion
  function automatic logic [3:0] next_state(input logic [3:0] st, input logic rw);
    case (st)
      ST_START:  next_state = ST_DEV_W;
      ST_DEV_W:  next_state = ST_REG;
      ST_REG:    next_state = rw ? ST_RSTART : ST_DATA_W;
      ST_DATA_W: next_state = ST_STOP;
      ST_RSTART: next_state = ST_DEV_R;
      ST_DEV_R:  next_state = ST_DATA_R;
      ST_DATA_R: next_state = ST_STOP;
      ST_STOP:   next_state = ST_RESP;
      default:   next_state = ST_IDLE;
    endcase
  endfunction

  // states whose command is a byte write and can therefore be NACKed
  function automatic logic is_wr_state(input logic [3:0] st);
    is_wr_state = (st == ST_DEV_W) || (st == ST_REG) || (st == ST_DATA_W) || (st == ST_DEV_R);
  endfunction

endpackage

// File: rtl/i2c_timeout_cnt.sv
// rtl/i2c_timeout_cnt.sv - 16-bit wait counter flagging an engine that never completes
module i2c_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt;

  // count cycles spent waiting; restarts whenever a new command is handed over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (clear) begin
      cnt <= 16'd0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  // expires on the LIMIT-th wait cycle so the sequencer leaves on that edge
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/i2c_xfer_ctrl.sv
// rtl/i2c_xfer_ctrl.sv - sequences single-register I2C reads/writes into byte-engine commands
module i2c_xfer_ctrl
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_data,
  output logic       cmd_nack,
  input  logic       done_valid,
  input  logic [7:0] done_data,
  input  logic       done_nack,
  output logic       busy
);

  logic [3:0] state;
  logic       phase;
  logic       armed;
  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       err_q;
  logic [7:0] rdata_q;
  logic       expired;
  logic       in_wait;

  assign in_wait = (phase == PH_WAIT);

  i2c_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cmd_valid && cmd_ready),
    .en      (in_wait),
    .expired (expired)
  );

  // armed keeps req_ready low while reset is held and for the reset cycle itself
  assign req_ready = armed && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

  // command presented to the byte engine, held constant for the whole issue phase
  always_comb begin
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'd0;
    cmd_nack  = 1'b0;
    if (phase == PH_ISSUE) begin
      case (state)
        ST_START:  begin cmd_valid = 1'b1; cmd_op = OP_START; end
        ST_DEV_W:  begin cmd_valid = 1'b1; cmd_op = OP_WR; cmd_data = {dev_q, 1'b0}; end
        ST_REG:    begin cmd_valid = 1'b1; cmd_op = OP_WR; cmd_data = reg_q; end
        ST_DATA_W: begin cmd_valid = 1'b1; cmd_op = OP_WR; cmd_data = wdata_q; end
        ST_RSTART: begin cmd_valid = 1'b1; cmd_op = OP_RSTART; end
        ST_DEV_R:  begin cmd_valid = 1'b1; cmd_op = OP_WR; cmd_data = {dev_q, 1'b1}; end
        ST_DATA_R: begin cmd_valid = 1'b1; cmd_op = OP_RD; cmd_nack = 1'b1; end
        ST_STOP:   begin cmd_valid = 1'b1; cmd_op = OP_STOP; end
        default:   cmd_valid = 1'b0;
      endcase
    end
  end

  // sequencer: accept, walk the command list, divert to STOP on NACK/timeout, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      phase   <= PH_ISSUE;
      armed   <= 1'b0;
      rw_q    <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wdata_q <= 8'd0;
      err_q   <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      armed <= 1'b1;
      if (state == ST_IDLE) begin
        if (req_valid && req_ready) begin
          rw_q    <= req_rw;
          dev_q   <= req_dev;
          reg_q   <= req_reg;
          wdata_q <= req_wdata;
          err_q   <= 1'b0;
          state   <= ST_START;
          phase   <= PH_ISSUE;
        end
      end else if (state == ST_RESP) begin
        state <= ST_IDLE;
        phase <= PH_ISSUE;
      end else if (phase == PH_ISSUE) begin
        if (cmd_valid && cmd_ready) begin
          phase <= PH_WAIT;
        end
      end else if (done_valid) begin
        // completion takes priority over a timeout landing in the same cycle
        phase <= PH_ISSUE;
        if (state == ST_DATA_R) begin
          rdata_q <= done_data;
        end
        if (is_wr_state(state) && done_nack) begin
          err_q <= 1'b1;
          state <= ST_STOP;
        end else begin
          state <= next_state(state, rw_q);
        end
      end else if (expired) begin
        err_q <= 1'b1;
        phase <= PH_ISSUE;
        state <= (state == ST_STOP) ? ST_RESP : ST_STOP;
      end
    end
  end

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// tb/tb_i2c_xfer_ctrl.sv - scoreboard bench for the I2C transfer controller
module tb_i2c_xfer_ctrl;
  import i2c_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       done_valid;
  logic [7:0] done_data;
  logic       done_nack;
  logic       busy;

  always #5 clk = ~clk;

  i2c_xfer_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_dev    (req_dev),
    .req_reg    (req_reg),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_nack   (cmd_nack),
    .done_valid (done_valid),
    .done_data  (done_data),
    .done_nack  (done_nack),
    .busy       (busy)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    logic       chk_rd;
  } rsp_t;

  logic [11:0] cmd_q[$];
  rsp_t        rsp_q[$];

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [7:0] d, input logic n);
    return {op, d, n};
  endfunction

  // engine model controls
  int         ready_dly = 0;
  int         done_dly  = 2;
  int         nack_idx  = -1;
  int         hold_idx  = -1;
  int         eng_idx   = 0;
  logic       spur      = 1'b0;
  logic [7:0] rd_byte   = 8'h00;

  // byte-engine model: delayed ready, delayed done, optional NACK / withheld done
  initial begin
    int st;
    int wc;
    int cur;
    logic [2:0] op_l;
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    done_nack  = 1'b0;
    done_data  = 8'h00;
    st = 0; wc = 0; cur = 0; op_l = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      cmd_ready  = 1'b0;
      done_valid = 1'b0;
      done_nack  = 1'b0;
      if (rst) begin
        st = 0;
      end else begin
        case (st)
          0: if (cmd_valid) begin
               op_l = cmd_op;
               if (ready_dly == 0) begin cmd_ready = 1'b1; st = 2; end
               else begin wc = ready_dly; st = 1; end
             end
          1: begin
               if (spur) begin done_valid = 1'b1; done_nack = 1'b1; end
               wc--;
               if (wc == 0) begin cmd_ready = 1'b1; st = 2; end
             end
          2: begin
               cur = eng_idx;
               eng_idx++;
               if (cur == hold_idx) st = 0;
               else begin wc = done_dly; st = 3; end
             end
          default: begin
               if (wc == 0) begin
                 done_valid = 1'b1;
                 done_nack  = (cur == nack_idx) && (op_l == OP_WR);
                 done_data  = rd_byte;
                 st = 0;
               end else begin
                 wc--;
               end
             end
        endcase
      end
    end
  end

  logic        pend = 1'b0;
  logic [11:0] pend_cmd = 12'd0;
  logic [11:0] exp_cmd;
  rsp_t        exp_rsp;
  int          gap = 0;
  int          stop_gap = -1;

  // monitor: command handshakes, issue-phase stability, WAIT gap before STOP, responses
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      gap  = 0;
    end else begin
      if (pend) begin
        check("hold_valid", 32'(cmd_valid), 32'd1);
        check("hold_cmd", 32'({cmd_op, cmd_data, cmd_nack}), 32'(pend_cmd));
      end
      pend     = cmd_valid && !cmd_ready;
      pend_cmd = {cmd_op, cmd_data, cmd_nack};
      if (cmd_valid) begin
        if (gap > 0 && cmd_op == OP_STOP) stop_gap = gap;
        gap = 0;
      end else if (busy) begin
        gap++;
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) begin
          check("cmd_extra", 32'({cmd_op, cmd_data, cmd_nack}), 32'hFFFF);
        end else begin
          exp_cmd = cmd_q.pop_front();
          check("cmd", 32'({cmd_op, cmd_data, cmd_nack}), 32'(exp_cmd));
        end
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_extra", 32'(rsp_valid), 32'd0);
        end else begin
          exp_rsp = rsp_q.pop_front();
          check("rsp_err", 32'(rsp_err), 32'(exp_rsp.err));
          if (exp_rsp.chk_rd) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp.rdata));
        end
      end
    end
  end

  // mode 0: normal, 1: NACK on device-address write, 2: done withheld after register write
  task automatic push_exp(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input int mode, input logic [7:0] rb);
    rsp_t r;
    eng_idx  = 0;
    nack_idx = (mode == 1) ? 1 : -1;
    hold_idx = (mode == 2) ? 2 : -1;
    rd_byte  = rb;
    cmd_q.push_back(mk(OP_START, 8'h00, 1'b0));
    cmd_q.push_back(mk(OP_WR, {dev, 1'b0}, 1'b0));
    if (mode == 1) begin
      cmd_q.push_back(mk(OP_STOP, 8'h00, 1'b0));
    end else begin
      cmd_q.push_back(mk(OP_WR, rg, 1'b0));
      if (mode == 2) begin
        cmd_q.push_back(mk(OP_STOP, 8'h00, 1'b0));
      end else if (rw) begin
        cmd_q.push_back(mk(OP_RSTART, 8'h00, 1'b0));
        cmd_q.push_back(mk(OP_WR, {dev, 1'b1}, 1'b0));
        cmd_q.push_back(mk(OP_RD, 8'h00, 1'b1));
        cmd_q.push_back(mk(OP_STOP, 8'h00, 1'b0));
      end else begin
        cmd_q.push_back(mk(OP_WR, wd, 1'b0));
        cmd_q.push_back(mk(OP_STOP, 8'h00, 1'b0));
      end
    end
    r.err    = (mode != 0);
    r.rdata  = rb;
    r.chk_rd = rw && (mode == 0);
    rsp_q.push_back(r);
  endtask

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic xfer(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [7:0] wd, input int mode, input logic [7:0] rb);
    int t;
    push_exp(rw, dev, rg, wd, mode, rb);
    send_req(rw, dev, rg, wd);
    t = 0;
    while (rsp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rsp_seen", 32'(rsp_q.size()), 32'd0);
    check("cmd_left", 32'(cmd_q.size()), 32'd0);
    cmd_q.delete();
    rsp_q.delete();
    @(negedge clk);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_dev   = 7'h00;
    req_reg   = 8'h00;
    req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd", 32'({cmd_valid, cmd_op, cmd_data, cmd_nack}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    xfer(1'b0, 7'h50, 8'h10, 8'hA5, 0, 8'h00);
    xfer(1'b1, 7'h50, 8'h20, 8'h00, 0, 8'h3C);
    xfer(1'b0, 7'h50, 8'h10, 8'hA5, 1, 8'h00);
    check("rdata_hold", 32'(rsp_rdata), 32'h3C);
    stop_gap = -1;
    xfer(1'b0, 7'h50, 8'h10, 8'hA5, 2, 8'h00);
    check("timeout_gap", 32'(stop_gap), 32'(TO));
    xfer(1'b1, 7'h50, 8'h30, 8'h00, 2, 8'h00);

    ready_dly = 5;
    spur      = 1'b1;
    xfer(1'b0, 7'h2A, 8'h33, 8'h5C, 0, 8'h00);
    xfer(1'b1, 7'h2A, 8'h44, 8'h00, 0, 8'hC3);
    ready_dly = 0;
    spur      = 1'b0;

    // reset while the data byte is being issued
    push_exp(1'b0, 7'h11, 8'h22, 8'h77, 0, 8'h00);
    send_req(1'b0, 7'h11, 8'h22, 8'h77);
    t = 0;
    while (!(cmd_valid && cmd_op == OP_WR && cmd_data == 8'h77) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reach_data_w", 32'(cmd_data), 32'h77);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cmd", 32'({cmd_valid, cmd_op, cmd_data, cmd_nack}), 32'd0);
    check("mid_rst_misc", 32'({busy, req_ready, rsp_valid, rsp_err}), 32'd0);
    check("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    cmd_q.delete();
    rsp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'({req_ready, busy, cmd_valid}), 32'b100);
    xfer(1'b0, 7'h11, 8'h22, 8'h77, 0, 8'h00);
    xfer(1'b1, 7'h11, 8'h22, 8'h00, 0, 8'h9E);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
